// File: rtl/trng_collector.sv
// trng_collector: consumer side of the ring-oscillator TRNG macro.
// The block warms up the macro, optionally debiases the raw bits with a
// von Neumann corrector, and packs the accepted bits into words. The words
// go out over a valid/ready handshake. A repetition-count health test on
// the raw stream latches a sticky failure flag.
module trng_collector #(
  parameter int WORD_WIDTH    = 32,
  parameter bit DEBIAS        = 1'b1,
  parameter int WARMUP_CYCLES = 16,
  parameter int REP_LIMIT     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  output logic                  trng_en,
  input  logic                  trng_out,
  output logic [WORD_WIDTH-1:0] rnd_data,
  output logic                  rnd_valid,
  input  logic                  rnd_ready,
  output logic                  health_fail
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WARMUP  = 3'd1,
    S_COLLECT = 3'd2,
    S_FULL    = 3'd3,
    S_FAIL    = 3'd4
  } state_e;

  localparam logic [7:0] WARM_LAST = 8'(WARMUP_CYCLES - 1);
  localparam logic [7:0] REP_MAX   = 8'(REP_LIMIT);
  localparam logic [6:0] CNT_LAST  = 7'(WORD_WIDTH - 1);

  state_e                state_q, state_d;
  logic                  trng_en_q, trng_en_d;
  logic [WORD_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  hf_q, hf_d;
  logic [7:0]            warm_q, warm_d;
  logic [7:0]            rep_q, rep_d;
  logic                  prev_q, prev_d;
  logic                  first_q, first_d;
  logic                  pair_have_q, pair_have_d;
  logic                  pair_bit_q, pair_bit_d;
  logic [WORD_WIDTH-1:0] shift_q, shift_d;
  logic [6:0]            cnt_q, cnt_d;
  logic [WORD_WIDTH-1:0] hold_q, hold_d;

  logic                  xfer_s;
  logic                  acc_s;
  logic                  acc_bit_s;
  logic [7:0]            rep_next_s;
  logic [WORD_WIDTH-1:0] shift_next_s;

  assign xfer_s = valid_q && rnd_ready;

  // Next-state, health test, debias and packing logic.
  always_comb begin
    state_d      = state_q;
    trng_en_d    = trng_en_q;
    data_d       = data_q;
    valid_d      = xfer_s ? 1'b0 : valid_q;
    hf_d         = hf_q;
    warm_d       = warm_q;
    rep_d        = rep_q;
    prev_d       = prev_q;
    first_d      = first_q;
    pair_have_d  = pair_have_q;
    pair_bit_d   = pair_bit_q;
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    hold_d       = hold_q;
    acc_s        = 1'b0;
    acc_bit_s    = 1'b0;
    rep_next_s   = rep_q;
    shift_next_s = shift_q;

    if (!enable) begin
      // Dropping enable abandons everything except an already-presented word.
      state_d     = S_IDLE;
      trng_en_d   = 1'b0;
      hf_d        = 1'b0;
      warm_d      = 8'd0;
      rep_d       = 8'd0;
      first_d     = 1'b0;
      pair_have_d = 1'b0;
      cnt_d       = 7'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d   = S_WARMUP;
          trng_en_d = 1'b1;
          warm_d    = 8'd0;
        end
        S_WARMUP: begin
          if (warm_q == WARM_LAST) begin
            state_d     = S_COLLECT;
            first_d     = 1'b1;
            pair_have_d = 1'b0;
            cnt_d       = 7'd0;
          end else begin
            warm_d = warm_q + 8'd1;
          end
        end
        S_COLLECT: begin
          if (first_q || (trng_out != prev_q)) begin
            rep_next_s = 8'd1;
          end else begin
            rep_next_s = rep_q + 8'd1;
          end
          rep_d   = rep_next_s;
          prev_d  = trng_out;
          first_d = 1'b0;
          if (rep_next_s == REP_MAX) begin
            state_d     = S_FAIL;
            hf_d        = 1'b1;
            trng_en_d   = 1'b0;
            pair_have_d = 1'b0;
            cnt_d       = 7'd0;
          end else begin
            if (DEBIAS) begin
              if (!pair_have_q) begin
                pair_have_d = 1'b1;
                pair_bit_d  = trng_out;
              end else begin
                pair_have_d = 1'b0;
                acc_s       = (pair_bit_q != trng_out);
                acc_bit_s   = pair_bit_q;
              end
            end else begin
              acc_s     = 1'b1;
              acc_bit_s = trng_out;
            end
            if (acc_s) begin
              shift_next_s = {shift_q[WORD_WIDTH-2:0], acc_bit_s};
              shift_d      = shift_next_s;
              if (cnt_q == CNT_LAST) begin
                cnt_d = 7'd0;
                // A free (or simultaneously drained) output takes the word directly.
                if (!valid_q || xfer_s) begin
                  data_d  = shift_next_s;
                  valid_d = 1'b1;
                end else begin
                  hold_d  = shift_next_s;
                  state_d = S_FULL;
                end
              end else begin
                cnt_d = cnt_q + 7'd1;
              end
            end else begin
              shift_d = shift_q;
            end
          end
        end
        S_FULL: begin
          if (xfer_s) begin
            data_d  = hold_q;
            valid_d = 1'b1;
            state_d = S_COLLECT;
          end else begin
            state_d = S_FULL;
          end
        end
        S_FAIL: begin
          state_d   = S_FAIL;
          trng_en_d = 1'b0;
        end
        default: begin
          state_d   = S_IDLE;
          trng_en_d = 1'b0;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      trng_en_q   <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      hf_q        <= 1'b0;
      warm_q      <= 8'd0;
      rep_q       <= 8'd0;
      prev_q      <= 1'b0;
      first_q     <= 1'b0;
      pair_have_q <= 1'b0;
      pair_bit_q  <= 1'b0;
      shift_q     <= '0;
      cnt_q       <= 7'd0;
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      trng_en_q   <= trng_en_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      hf_q        <= hf_d;
      warm_q      <= warm_d;
      rep_q       <= rep_d;
      prev_q      <= prev_d;
      first_q     <= first_d;
      pair_have_q <= pair_have_d;
      pair_bit_q  <= pair_bit_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
    end
  end

  assign trng_en     = trng_en_q;
  assign rnd_data    = data_q;
  assign rnd_valid   = valid_q;
  assign health_fail = hf_q;

endmodule

// File: tb/tb_trng_collector.sv
// Bench for trng_collector: table-driven debias vectors on a default
// instance, plus hand sequences for health failure and asynchronous reset.
// A randomized backpressure run on an 8-bit raw-mode instance is scored
// against words rebuilt from the sampled bit stream.
module tb_trng_collector;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        en_a, trng_a, rdy_a, ten_a, vld_a, hf_a;
  logic [31:0] dat_a;
  logic        en_b, trng_b, rdy_b, ten_b, vld_b, hf_b;
  logic [7:0]  dat_b;

  trng_collector dut_a (
    .clk(clk), .rst_n(rst_n), .enable(en_a), .trng_en(ten_a), .trng_out(trng_a),
    .rnd_data(dat_a), .rnd_valid(vld_a), .rnd_ready(rdy_a), .health_fail(hf_a)
  );

  trng_collector #(.WORD_WIDTH(8), .DEBIAS(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(en_b), .trng_en(ten_b), .trng_out(trng_b),
    .rnd_data(dat_b), .rnd_valid(vld_b), .rnd_ready(rdy_b), .health_fail(hf_b)
  );

  int checks = 0;
  int errs   = 0;
  int cyc    = 0;
  int mode_a = 0;
  int popped = 0;
  int nacc   = 0;
  bit track_b = 1'b0;
  logic [7:0] wacc;
  logic [7:0] exp_q[$];

  typedef struct {
    int          mode;
    logic [31:0] exp_data;
    int          exp_edge;
  } vec_t;

  vec_t vt[3];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Raw pattern seen at edge k; phase 0 lines up with the first COLLECT sample (edge 18).
  function automatic logic pat_bit(input int k, input int mode);
    int p;
    p = (k + 4000 - 18) % 4;
    case (mode)
      0: return (p % 2) == 0;
      1: return (p % 2) == 1;
      2: return p != 3;
      default: return 1'b0;
    endcase
  endfunction

  // One clock: drive inputs, score any transfer on dut_b, rebuild expected words.
  task automatic tick;
    int k;
    k = cyc + 1;
    trng_a = pat_bit(k, mode_a);
    trng_b = ($urandom() % 2) == 1;
    if (vld_b && rdy_b) begin
      if (exp_q.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL b_word: got %0h expected no word (edge %0d)", dat_b, k);
      end else begin
        chk("b_word", dat_b, exp_q.pop_front());
      end
      popped++;
    end
    @(posedge clk);
    cyc++;
    if (track_b && ((cyc >= 18 && cyc <= 33) || cyc >= 41)) begin
      wacc = {wacc[6:0], trng_b};
      nacc++;
      if (nacc == 8) begin
        exp_q.push_back(wacc);
        nacc = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    en_a = 1'b0; en_b = 1'b0; rdy_a = 1'b0; rdy_b = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cyc = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; trng_a = 1'b0; trng_b = 1'b0;
    vt[0] = '{0, 32'hFFFF_FFFF, 81};
    vt[1] = '{1, 32'h0000_0000, 81};
    vt[2] = '{2, 32'hFFFF_FFFF, 145};

    do_reset();
    chk("reset_trng_en", ten_a, 1'b0);
    chk("reset_valid", vld_a, 1'b0);
    chk("reset_data", dat_a, 32'h0);
    chk("reset_hf", hf_a, 1'b0);

    // Debias vectors: value and arrival time of the first word.
    for (int i = 0; i < 3; i++) begin
      do_reset();
      mode_a = vt[i].mode;
      en_a = 1'b1;
      chk("trng_en_before", ten_a, 1'b0);
      tick();
      chk("trng_en_rise", ten_a, 1'b1);
      while (cyc < vt[i].exp_edge - 1) tick();
      chk("valid_early", vld_a, 1'b0);
      tick();
      chk("valid_rise", vld_a, 1'b1);
      chk("debias_data", dat_a, vt[i].exp_data);
      chk("hf_quiet", hf_a, 1'b0);
    end

    // Asynchronous reset with a word pending, between clock edges.
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_valid", vld_a, 1'b0);
    chk("async_data", dat_a, 32'h0);
    chk("async_trng_en", ten_a, 1'b0);
    chk("async_hf", hf_a, 1'b0);
    @(negedge clk);

    // Health failure on a stuck-at-0 stream, then recovery through IDLE.
    do_reset();
    mode_a = 3;
    en_a = 1'b1;
    while (cyc < 48) tick();
    chk("hf_before", hf_a, 1'b0);
    chk("ten_before_fail", ten_a, 1'b1);
    tick();
    chk("hf_set", hf_a, 1'b1);
    chk("ten_fail", ten_a, 1'b0);
    chk("no_word_fail", vld_a, 1'b0);
    en_a = 1'b0;
    tick();
    chk("hf_cleared", hf_a, 1'b0);
    chk("ten_idle", ten_a, 1'b0);
    en_a = 1'b1;
    tick();
    chk("ten_rewarm", ten_a, 1'b1);
    while (cyc < 98) tick();
    chk("hf_rewarm_before", hf_a, 1'b0);
    tick();
    chk("hf_rewarm_set", hf_a, 1'b1);

    // Backpressure on the raw 8-bit instance.
    do_reset();
    exp_q.delete();
    nacc = 0;
    popped = 0;
    track_b = 1'b1;
    en_b = 1'b1;
    while (cyc < 24) tick();
    chk("b_valid_early", vld_b, 1'b0);
    tick();
    chk("b_valid_rise", vld_b, 1'b1);
    chk("b_word1", dat_b, exp_q[0]);
    while (cyc < 39) begin
      tick();
      chk("b_word1_stable", dat_b, exp_q[0]);
      chk("b_valid_stalled", vld_b, 1'b1);
    end
    chk("b_two_words", exp_q.size(), 2);
    chk("b_ten_full", ten_b, 1'b1);
    rdy_b = 1'b1;
    tick();
    rdy_b = 1'b0;
    chk("b_valid_b2b", vld_b, 1'b1);
    chk("b_word2", dat_b, exp_q[0]);
    rdy_b = 1'b1;
    repeat (80) tick();
    chk("b_delivered", popped, 11);
    chk("b_pending", exp_q.size(), 1);
    chk("b_hf", hf_b, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end

endmodule
